// File: rtl/move_request_if.sv
// Purpose: groups button, pause and handshake inputs with the move request outputs.
// Latency: none, this file only declares wires.
// Backpressure: checkBoard is held until doneLogic arrives, so the consumer sets the pace.
interface move_request_if;
    logic [3:0] btn_n;
    logic       paused;
    logic       doneLogic;
    logic       checkBoard;
    logic       DropBlock;
    logic       LeftBlock;
    logic       RightBlock;
    logic       DownBlock;

    // Driver side: the board and game-logic FSM.
    modport master (
        output btn_n, paused, doneLogic,
        input  checkBoard, DropBlock, LeftBlock, RightBlock, DownBlock
    );

    // Request unit side.
    modport slave (
        input  btn_n, paused, doneLogic,
        output checkBoard, DropBlock, LeftBlock, RightBlock, DownBlock
    );
endinterface

// File: rtl/move_request_unit.sv
// Purpose: debounced buttons and a gravity timer become one-hot move requests with a checkBoard strobe.
// Latency: a press reaches its pending flag DEBOUNCE_CYCLES+2 cycles after it is stable, and is issued 1 cycle later.
// Backpressure: one request is held until doneLogic; later events wait in one-deep sticky pending flags.
module move_request_unit #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int GRAVITY_TICKS   = 25_000_000
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    move_request_if.slave bus
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW  = $clog2(GRAVITY_TICKS);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0]  GR_LAST = GW'(GRAVITY_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Bit order everywhere: [3] drop, [2] left, [1] right, [0] down.
    logic [3:0]     r_sync1, r_sync2;
    logic [3:0]     r_db_lvl, r_db_lvl_d;
    logic [DBW-1:0] r_db_cnt [4];
    logic [3:0]     w_press;
    logic [GW-1:0]  r_grav_cnt;
    logic           w_tick;
    logic [3:0]     w_event;
    logic [3:0]     r_pend;
    logic [3:0]     w_issue;
    state_t         r_state, w_state_nxt;
    logic [3:0]     r_move, w_move_nxt;
    logic           r_check;

    // Two-flop synchroniser on the raw buttons; the reset value means released.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: accept a new level only after it differs for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_db_lvl   <= '1;
            r_db_lvl_d <= '1;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_db_lvl_d <= r_db_lvl;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the press edge (1->0) counts. Releases are ignored.
    assign w_press = r_db_lvl_d & ~r_db_lvl;
    assign w_tick  = (r_grav_cnt == GR_LAST) && !bus.paused;
    assign w_event = {w_press[3:1], w_press[0] | w_tick};

    // Gravity counter: wraps every GRAVITY_TICKS cycles, holds while paused.
    // It restarts whenever a drop or down move is issued.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_grav_cnt <= '0;
        end else if (w_issue[3] || w_issue[0]) begin
            r_grav_cnt <= '0;
        end else if (!bus.paused) begin
            r_grav_cnt <= (r_grav_cnt == GR_LAST) ? '0 : r_grav_cnt + 1'b1;
        end
    end

    // Sticky one-deep pending flags. A new event wins over the issue-clear in the same cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_issue) | w_event;
        end
    end

    // Next-state and next-output decode. Priority is drop > left > right > down,
    // matching the decode order in the logic FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_move_nxt  = r_move;
        w_issue     = '0;
        case (r_state)
            S_IDLE: begin
                w_move_nxt = '0;
                if (|r_pend) begin
                    w_state_nxt = S_ISSUE;
                    if (r_pend[3])      w_issue = 4'b1000;
                    else if (r_pend[2]) w_issue = 4'b0100;
                    else if (r_pend[1]) w_issue = 4'b0010;
                    else                w_issue = 4'b0001;
                    w_move_nxt = w_issue;
                end
            end
            S_ISSUE: begin
                if (bus.doneLogic) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                // The move stays visible for one more cycle so the FSM sees it while exiting.
                w_state_nxt = S_IDLE;
                w_move_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_move_nxt  = '0;
            end
        endcase
    end

    // State and outputs registered together, so outputs line up with the state.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
            r_move  <= '0;
            r_check <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_move  <= w_move_nxt;
            r_check <= (w_state_nxt == S_ISSUE);
        end
    end

    assign bus.checkBoard = r_check;
    assign bus.DropBlock  = r_move[3];
    assign bus.LeftBlock  = r_move[2];
    assign bus.RightBlock = r_move[1];
    assign bus.DownBlock  = r_move[0];
endmodule

// File: doc/move_request_unit.md
# move_request_unit

Front-end for the game-logic FSM: turns raw active-low push-buttons and a gravity timer into one-hot move requests (DropBlock, LeftBlock, RightBlock, DownBlock) plus the checkBoard strobe. It synchronises and debounces the buttons and queues at most one pending request per move kind. It presents exactly one request at a time and holds it until the logic FSM signals doneLogic, then releases it cleanly so the FSM can return to idle.

## Interface
- DEBOUNCE_CYCLES, 500_000: consecutive stable synchronised samples needed to accept a button level change (10 ms at 50 MHz).
- GRAVITY_TICKS, 25_000_000: CLOCK_50 cycles per automatic down request (0.5 s).
- CLOCK_50  input  1  system clock; all state changes on its rising edge.
- Resetn  input  1  synchronous, active-low reset.
- btn_n  input  4  raw asynchronous buttons, active-low: [3] drop, [2] left, [1] right, [0] down.
- paused  input  1  when high, the gravity counter holds its value; button events still queue.
- doneLogic  input  1  logic FSM finished applying the presented move.
- checkBoard  output  1  request valid; high from issue until the cycle after doneLogic.
- DropBlock, LeftBlock, RightBlock, DownBlock  output  1 each  one-hot move select; at most one high.

## Operation
- Input path, per button:
  - 2-FF synchroniser, reset to 1 (released).
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1). It resets to 0 whenever the synchronised level equals the debounced level. Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 with the level still differing, the debounced level takes the new value and the counter clears.
  - Debounced level resets to 1.
  - Press event: a one-cycle pulse when the debounced level goes 1->0. Releases generate nothing.
- Gravity:
  - Counter width $clog2(GRAVITY_TICKS), counts 0..GRAVITY_TICKS-1 and wraps to 0.
  - A tick occurs in the cycle the counter is at GRAVITY_TICKS-1 and paused=0; the tick sets pend_down.
  - When paused=1 the counter holds.
  - The counter clears to 0 in the cycle a Drop or Down request is issued.
- Pending flags pend_drop/left/right/down:
  - Sticky and one deep; repeated events while a flag is set are absorbed.
  - A flag clears in the cycle its request is issued.
  - If a new event of the same kind arrives in that same cycle, set wins and the flag stays 1.
- Selection priority: drop > left > right > down. This matches the logic FSM's decode order.
- State machine, 2-bit state register, reset to IDLE:
  - IDLE: all outputs 0. If any pending flag is set, latch the highest-priority kind, clear its flag, go to ISSUE. Otherwise stay.
  - ISSUE: checkBoard=1 and the latched move=1. doneLogic=1 -> RELEASE. doneLogic=0 -> stay (no timeout).
  - RELEASE: checkBoard=0, latched move still 1, so the FSM's moveDown state sees the move during its exit. Unconditionally -> IDLE.
- Outputs are registered, decoded from the next state so they align with the state register. No combinational path from btn_n or doneLogic to any output.
- doneLogic outside ISSUE is ignored.
- Events arriving during ISSUE/RELEASE only set pending flags.

## Timing
- Reset: all outputs 0, state IDLE, pending flags 0, gravity and debounce counters 0, synchroniser and debounced levels 1. Reset asserted mid-request drops the request and all pending flags at the next edge.
- Button latency: a clean press stable from edge t raises its pending flag at edge t+2+DEBOUNCE_CYCLES (2 for the synchroniser, DEBOUNCE_CYCLES for the debouncer).
- Issue latency: pending flag set at edge p while in IDLE -> checkBoard and move high after edge p+1.
- Handshake: doneLogic sampled high at edge d -> checkBoard low after d. Move low after d+1 (IDLE). The earliest next checkBoard rise is after d+2.
- The first gravity tick after reset occurs GRAVITY_TICKS cycles after Resetn deasserts, assuming paused=0 and no Drop/Down issued.
- Simultaneous events in one cycle are all recorded. They are issued one per transaction in priority order.

## Test plan
- Use DEBOUNCE_CYCLES=4 and GRAVITY_TICKS=20 unless stated.
- Reset: hold Resetn=0 for 3 cycles with btn_n=0000 -> all outputs 0. After release, no press event until 6 stable cycles have passed.
- Bounce: toggle btn_n[2] every 2 cycles for 12 cycles, then hold it at 0 -> exactly one LeftBlock request, with checkBoard rising 7 cycles after the stable hold begins.
- Handshake: left request issued, doneLogic pulsed after 5 cycles -> checkBoard falls the next cycle, LeftBlock falls one cycle later, no second request.
- Priority and queueing: press drop, right and down in the same cycle -> three transactions in the order Drop, Right, Down, each issued only after the previous doneLogic.
- Gravity: with no buttons pressed, observe checkBoard rises 21 cycles after reset with DownBlock=1. With paused=1 from cycle 10, no request occurs. With paused=0 again, the tick resumes from count 10.
- Sticky set-wins: a down event lands in the same cycle the pending down is issued -> a second Down transaction follows the first.
